alu_mc: RTL and testbench

Multi-cycle, parametrised ALU for the datapath. It extends the single-cycle 32-bit ALU with a configurable word width, registered outputs and a start/busy/done handshake. It adds iterative unsigned multiply and divide, plus a signed-overflow flag. The control unit issues one operation at a time and waits for `done` before consuming `result`.

---
 rtl/alu_mc.sv | 173 +++++++++++++++++
 tb/tb_alu_mc.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle parametrised ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             cero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  localparam int SW = $clog2(WIDTH);

  // Handshake: an op is accepted on a rising edge with start=1 and busy=0;
  // done pulses for one cycle when result/cero/ovf carry a new value.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cero_q, cero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_acc, step_lo, fin_res;
  logic [SW-1:0]    sh_amt;
  logic             is_iter, last;

  assign sh_amt  = b[SW-1:0];
  assign is_iter = (op[3:2] == 2'b10);
  assign last    = (cnt_q == SW'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = a + b;
    diff    = a - b;
    case (op)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0011: alu_res = a ^ b;
      4'b1100: alu_res = ~(a | b);
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: alu_res[0] = ($signed(a) < $signed(b));
      4'b0100: alu_res = a << sh_amt;
      4'b0101: alu_res = a >> sh_amt;
      default: alu_res = '0;
    endcase
  end

  // Multiply: {acc,lo} shifts right with the multiplier in lo. Divide: {acc,lo}
  // shifts left with the dividend in lo and quotient bits entering at lo[0].
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[1]) begin
      if (!div_diff[WIDTH]) begin
        step_acc = div_diff[WIDTH-1:0];
        step_lo  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_shift[WIDTH-1:0];
        step_lo  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    fin_res = op_q[0] ? step_acc : step_lo;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    result_d = result_q;
    cero_d   = cero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_iter) begin
            state_d = S_RUN;
            cnt_d   = '0;
            op_d    = op;
            opnd_d  = op[1] ? b : a;
            lo_d    = op[1] ? a : b;
            acc_d   = '0;
          end else begin
            result_d = alu_res;
            cero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + SW'(1);
        if (last) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          result_d = fin_res;
          cero_d   = (fin_res == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
      cero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      cero_q   <= cero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result    = result_q;
  assign cero      = cero_q;
  assign ovf       = ovf_q;
  assign done      = done_q;
  assign busy      = (state_q == S_RUN);
  assign dbg_state = (state_q == S_RUN);

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and an 8-bit instance share stimulus; results are
// checked against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic [3:0]  op;

  logic [31:0] result32;
  logic        cero32, ovf32, busy32, done32, dbg32;
  logic [7:0]  result8;
  logic        cero8, ovf8, busy8, done8, dbg8;

  int errors = 0;
  int checks = 0;
  bit use8   = 1'b0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
    .result(result32), .cero(cero32), .ovf(ovf32), .busy(busy32), .done(done32),
    .dbg_state(dbg32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .a(a[7:0]), .b(b[7:0]), .op(op),
    .result(result8), .cero(cero8), .ovf(ovf8), .busy(busy8), .done(done8),
    .dbg_state(dbg8)
  );

  function automatic logic [31:0] cur_result();
    return use8 ? {24'h0, result8} : result32;
  endfunction
  function automatic logic cur_cero();
    return use8 ? cero8 : cero32;
  endfunction
  function automatic logic cur_ovf();
    return use8 ? ovf8 : ovf32;
  endfunction
  function automatic logic cur_busy();
    return use8 ? busy8 : busy32;
  endfunction
  function automatic logic cur_done();
    return use8 ? done8 : done32;
  endfunction

  // Reference model: plain integer arithmetic on width w (w <= 32).
  function automatic void model(input int w, input logic [3:0] o, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] r, output logic v);
    longint unsigned m, ua, ub, hu, res;
    longint          sa, sb, s, half;
    m    = (64'd1 << w) - 1;
    ua   = x & m;
    ub   = y & m;
    hu   = 64'd1 << (w - 1);
    half = longint'(hu);
    sa   = (ua & hu) != 0 ? longint'(ua) - 2 * half : longint'(ua);
    sb   = (ub & hu) != 0 ? longint'(ub) - 2 * half : longint'(ub);
    v    = 1'b0;
    res  = 0;
    case (o)
      4'd0:  res = ua & ub;
      4'd1:  res = ua | ub;
      4'd3:  res = ua ^ ub;
      4'd12: res = ~(ua | ub) & m;
      4'd2: begin
        s = sa + sb;
        res = (ua + ub) & m;
        v = (s > half - 1) || (s < -half);
      end
      4'd6: begin
        s = sa - sb;
        res = (ua - ub) & m;
        v = (s > half - 1) || (s < -half);
      end
      4'd7:  res = (sa < sb) ? 1 : 0;
      4'd4:  res = (ua << (ub % w)) & m;
      4'd5:  res = ua >> (ub % w);
      4'd8:  res = (ua * ub) & m;
      4'd9:  res = ((ua * ub) >> w) & m;
      4'd10: res = (ub == 0) ? m : ua / ub;
      4'd11: res = (ub == 0) ? ua : ua % ub;
      default: res = 0;
    endcase
    r = res[31:0];
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy32 || busy8) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL idle_timeout busy32=%0b busy8=%0b required idle", busy32, busy8);
    end
  endtask

  // Issue one op; lat counts edges after acceptance until done is seen.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit inject, output bit got, output int lat, output int bcnt);
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 200) begin
      if (cur_done()) got = 1'b1;
      else begin
        if (cur_busy()) bcnt++;
        if (inject && lat == 10) begin
          start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd1;
        end
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    bit got; int lat, bc;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({result32, cero32, ovf32, busy32, done32} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset32 got res=%h cero=%b ovf=%b busy=%b done=%b", result32, cero32, ovf32, busy32, done32);
    end
    checks++;
    if ({result8, cero8, busy8, done8} !== {8'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset8 got res=%h cero=%b busy=%b done=%b", result8, cero8, busy8, done8);
    end
    @(negedge clk); reset = 1'b0;
    do_op(4'b0010, 32'd4, 32'd5, 1'b0, got, lat, bc);
    checks++;
    if (!got || lat != 0 || result32 !== 32'd9) begin
      errors++;
      $display("FAIL first_add got=%0b lat=%0d res=%h required res=9 lat=0", got, lat, result32);
    end
    @(posedge clk); #1;
    checks++;
    if (done32 !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle got done=%b required 0", done32);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  t_op[8]  = '{4'b0110, 4'b0110, 4'b0111, 4'b0111, 4'b0000, 4'b1100, 4'b0100, 4'b1111};
    logic [31:0] t_a[8]   = '{32'd4, 32'd5, 32'd4, 32'hFFFFFFFF, 32'd4, 32'd4, 32'd1, 32'd9};
    logic [31:0] t_b[8]   = '{32'd5, 32'd5, 32'd5, 32'd1, 32'd5, 32'd5, 32'd31, 32'd3};
    logic [31:0] t_exp[8] = '{32'hFFFFFFFF, 32'h0, 32'd1, 32'd1, 32'd4, 32'hFFFFFFFA, 32'h80000000, 32'h0};
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b1; op = t_op[i]; a = t_a[i]; b = t_b[i];
      @(posedge clk); #1;
      checks++;
      if ({done32, result32, cero32, ovf32} !== {1'b1, t_exp[i], t_exp[i] == 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL b2b[%0d] op=%b got done=%b res=%h cero=%b ovf=%b required res=%h",
                 i, t_op[i], done32, result32, cero32, ovf32, t_exp[i]);
      end
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done32 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_drop got done=%b required 0", done32);
    end
  endtask

  task automatic test_overflow();
    logic [3:0]  t_op[3]  = '{4'b0010, 4'b0110, 4'b0010};
    logic [31:0] t_a[3]   = '{32'h7FFFFFFF, 32'h80000000, 32'd4};
    logic [31:0] t_b[3]   = '{32'd1, 32'd1, 32'd5};
    logic [31:0] t_exp[3] = '{32'h80000000, 32'h7FFFFFFF, 32'd9};
    logic        t_v[3]   = '{1'b1, 1'b1, 1'b0};
    bit got; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 1'b0, got, lat, bc);
      checks++;
      if (!got || result32 !== t_exp[i] || ovf32 !== t_v[i]) begin
        errors++;
        $display("FAIL ovf[%0d] got res=%h ovf=%b required res=%h ovf=%b", i, result32, ovf32, t_exp[i], t_v[i]);
      end
    end
  endtask

  task automatic test_mul();
    bit got; int lat, bc;
    do_op(4'b1000, 32'h00010000, 32'h00010000, 1'b1, got, lat, bc);
    checks++;
    if (!got || result32 !== 32'h0 || cero32 !== 1'b1 || ovf32 !== 1'b0) begin
      errors++;
      $display("FAIL mullo got res=%h cero=%b ovf=%b required res=0 cero=1", result32, cero32, ovf32);
    end
    checks++;
    if (lat != 32 || bc != 32 || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL mul_timing got lat=%0d busy_cycles=%0d required 32/32", lat, bc);
    end
    @(posedge clk); #1;
    checks++;
    if (done32 !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_one_cycle got done=%b required 0", done32);
    end
    do_op(4'b1001, 32'h00010000, 32'h00010000, 1'b0, got, lat, bc);
    checks++;
    if (!got || result32 !== 32'd1 || cero32 !== 1'b0) begin
      errors++;
      $display("FAIL mulhi got res=%h cero=%b required res=1", result32, cero32);
    end
  endtask

  task automatic test_div();
    logic [3:0]  t_op[4]  = '{4'b1010, 4'b1011, 4'b1010, 4'b1011};
    logic [31:0] t_a[4]   = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] t_b[4]   = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] t_exp[4] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};
    bit got; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 1'b0, got, lat, bc);
      checks++;
      if (!got || lat != 32 || result32 !== t_exp[i]) begin
        errors++;
        $display("FAIL div[%0d] got res=%h lat=%0d required res=%h lat=32", i, result32, lat, t_exp[i]);
      end
    end
  endtask

  task automatic test_width8();
    bit got; int lat, bc;
    use8 = 1'b1;
    do_op(4'b1010, 32'd200, 32'd3, 1'b0, got, lat, bc);
    checks++;
    if (!got || lat != 8 || bc != 8 || result8 !== 8'd66) begin
      errors++;
      $display("FAIL divu8 got res=%0d lat=%0d busy_cycles=%0d required res=66 lat=8", result8, lat, bc);
    end
    use8 = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got; int lat, bc;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = 4'b1000; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({result32, cero32, ovf32, busy32, done32} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got res=%h cero=%b ovf=%b busy=%b done=%b", result32, cero32, ovf32, busy32, done32);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done32 !== 1'b0 || busy32 !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_nodone got done=%b busy=%b required 0/0", done32, busy32);
      end
    end
    do_op(4'b0010, 32'd2, 32'd2, 1'b0, got, lat, bc);
    checks++;
    if (!got || lat != 0 || result32 !== 32'd4) begin
      errors++;
      $display("FAIL post_reset_add got res=%h lat=%0d required res=4 lat=0", result32, lat);
    end
  endtask

  task automatic test_random(input bit w8, input int n);
    logic [3:0]  o;
    logic [31:0] x, y, er;
    logic        ev;
    bit got; int lat, bc, w, el;
    use8 = w8;
    w = w8 ? 8 : 32;
    for (int i = 0; i < n; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 40);
        default: y = $urandom;
      endcase
      model(w, o, x, y, er, ev);
      el = (o[3:2] == 2'b10) ? w : 0;
      do_op(o, x, y, 1'b0, got, lat, bc);
      checks++;
      if (!got || lat != el || cur_result() !== er || cur_cero() !== (er == 32'h0) || cur_ovf() !== ev) begin
        errors++;
        $display("FAIL rand%0d[%0d] op=%b a=%h b=%h got res=%h cero=%b ovf=%b lat=%0d required res=%h ovf=%b lat=%0d",
                 w, i, o, x, y, cur_result(), cur_cero(), cur_ovf(), lat, er, ev, el);
      end
    end
    use8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overflow();
    test_mul();
    test_div();
    test_width8();
    test_reset_mid();
    test_random(1'b0, 60);
    test_random(1'b1, 30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
